// File: rtl/ipmxb_hsst_lane_pwrup_seq_v2_0_if.sv
// HSST lane power-up sequencer bus: lane requests, PLL lock, status clear,
// and per-lane PD/RST/ready/pll-lost controls toward the hard macro.
interface ipmxb_hsst_lane_pwrup_seq_v2_0_if #(
  parameter int unsigned LANE_NUM = 4
) ();
  logic [LANE_NUM-1:0] i_lane_pd;
  logic [1:0]          i_pll_done;
  logic                i_clr_status;
  logic [LANE_NUM-1:0] P_LANE_PD;
  logic [LANE_NUM-1:0] P_LANE_RST;
  logic [LANE_NUM-1:0] o_lane_ready;
  logic [LANE_NUM-1:0] o_pll_lost;

  modport master (
    output i_lane_pd, i_pll_done, i_clr_status,
    input  P_LANE_PD, P_LANE_RST, o_lane_ready, o_pll_lost
  );

  modport slave (
    input  i_lane_pd, i_pll_done, i_clr_status,
    output P_LANE_PD, P_LANE_RST, o_lane_ready, o_pll_lost
  );
endinterface

// File: rtl/ipmxb_hsst_lane_pwrup_seq_v2_0.sv
// Per-group HSST lane power-up sequencer with PLL-loss re-sequencing.
// Ports: clk, rst (async high), bus (slave): pd/pll/clr in; PD/RST/ready/lost out.
module ipmxb_hsst_lane_pwrup_seq_v2_0 #(
  parameter int unsigned FREE_CLOCK_FREQ = 100,
  parameter int unsigned LANE_NUM        = 4,
  parameter logic [7:0]  LANE_EN         = 8'hFF,
  parameter logic [7:0]  PLL_SEL         = 8'h00,
  parameter int unsigned BOND_MODE       = 1,
  parameter int unsigned PD_DLY_US       = 40,
  parameter int unsigned RST_DLY_US      = 1
) (
  input logic clk,
  input logic rst,
  ipmxb_hsst_lane_pwrup_seq_v2_0_if.slave bus
);

  localparam int unsigned PD_CYCLES =
    2 * PD_DLY_US * FREE_CLOCK_FREQ;
  localparam int unsigned RST_CYCLES =
    2 * RST_DLY_US * FREE_CLOCK_FREQ;
  localparam int unsigned MAX_CYCLES =
    (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
  localparam int unsigned CNTR_WIDTH = $clog2(MAX_CYCLES + 1);
  localparam int unsigned GRP_NUM = LANE_NUM / BOND_MODE;

  localparam logic [CNTR_WIDTH-1:0] PD_LAST =
    CNTR_WIDTH'(PD_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] RST_LAST =
    CNTR_WIDTH'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT_PLL,
    ST_PD_WAIT,
    ST_RST_WAIT,
    ST_READY
  } state_e;

  logic [LANE_NUM-1:0] pd_meta_q;
  logic [LANE_NUM-1:0] pd_sync_q;
  logic [1:0]          pll_meta_q;
  logic [1:0]          pll_sync_q;

  // pd syncs reset to "powered down" so nothing starts before the
  // first real sample arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_meta_q  <= '1;
      pd_sync_q  <= '1;
      pll_meta_q <= '0;
      pll_sync_q <= '0;
    end else begin
      pd_meta_q  <= bus.i_lane_pd;
      pd_sync_q  <= pd_meta_q;
      pll_meta_q <= bus.i_pll_done;
      pll_sync_q <= pll_meta_q;
    end
  end

  // Non-master lane requests and an unselected PLL are legitimately ignored.
  logic unused_sync;
  assign unused_sync = ^{pd_sync_q, pll_sync_q};

  logic [GRP_NUM-1:0] grp_pd;
  logic [GRP_NUM-1:0] grp_rst;
  logic [GRP_NUM-1:0] grp_rdy;
  logic [GRP_NUM-1:0] grp_lost;

  for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
    localparam int unsigned M   = g * BOND_MODE;
    localparam bit          EN  = LANE_EN[M];
    localparam bit          SEL = PLL_SEL[M];

    state_e                state_q;
    state_e                state_d;
    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] cnt_d;
    logic                  lost_q;
    logic                  lost_d;
    logic                  lost_set;
    logic                  pd_req;
    logic                  pll_ok;

    assign pd_req = pd_sync_q[M];
    assign pll_ok = pll_sync_q[SEL];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        lost_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lost_q  <= lost_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lost_set = 1'b0;
      if (!EN) begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end else if (pd_req) begin
        // A power-down request hides any PLL loss in the same cycle.
        state_d = ST_OFF;
        cnt_d   = '0;
      end else if (!pll_ok &&
                   (state_q == ST_PD_WAIT ||
                    state_q == ST_RST_WAIT ||
                    state_q == ST_READY)) begin
        state_d  = ST_WAIT_PLL;
        cnt_d    = '0;
        lost_set = 1'b1;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_d = ST_WAIT_PLL;
            cnt_d   = '0;
          end
          ST_WAIT_PLL: begin
            if (pll_ok) begin
              state_d = ST_PD_WAIT;
              cnt_d   = '0;
            end
          end
          ST_PD_WAIT: begin
            if (cnt_q == PD_LAST) begin
              state_d = ST_RST_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTR_WIDTH'(1);
            end
          end
          ST_RST_WAIT: begin
            if (cnt_q == RST_LAST) begin
              state_d = ST_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTR_WIDTH'(1);
            end
          end
          ST_READY: begin
            state_d = ST_READY;
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Set beats a same-cycle clear.
    always_comb begin
      lost_d = lost_q;
      if (bus.i_clr_status) lost_d = 1'b0;
      if (lost_set)         lost_d = 1'b1;
    end

    assign grp_pd[g]   = (state_q != ST_RST_WAIT) &&
                         (state_q != ST_READY);
    assign grp_rst[g]  = (state_q != ST_READY);
    assign grp_rdy[g]  = (state_q == ST_READY);
    assign grp_lost[g] = lost_q;
  end

  logic [LANE_NUM-1:0] lane_pd;
  logic [LANE_NUM-1:0] lane_rst;
  logic [LANE_NUM-1:0] lane_rdy;
  logic [LANE_NUM-1:0] lane_lost;

  always_comb begin
    lane_pd   = '1;
    lane_rst  = '1;
    lane_rdy  = '0;
    lane_lost = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      lane_pd[l]   = grp_pd[l / BOND_MODE];
      lane_rst[l]  = grp_rst[l / BOND_MODE];
      lane_rdy[l]  = grp_rdy[l / BOND_MODE];
      lane_lost[l] = grp_lost[l / BOND_MODE];
    end
  end

  assign bus.P_LANE_PD    = lane_pd;
  assign bus.P_LANE_RST   = lane_rst;
  assign bus.o_lane_ready = lane_rdy;
  assign bus.o_pll_lost   = lane_lost;

endmodule

// File: tb/tb_ipmxb_hsst_lane_pwrup_seq_v2_0.sv
// Bench for the HSST lane power-up sequencer: three configurations
// (single lanes, 4-lane bond, lane 0 disabled) with an edge scoreboard.
module tb_ipmxb_hsst_lane_pwrup_seq_v2_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ipmxb_hsst_lane_pwrup_seq_v2_0_if #(.LANE_NUM(4)) bus_a ();
  ipmxb_hsst_lane_pwrup_seq_v2_0_if #(.LANE_NUM(4)) bus_b ();
  ipmxb_hsst_lane_pwrup_seq_v2_0_if #(.LANE_NUM(4)) bus_c ();

  ipmxb_hsst_lane_pwrup_seq_v2_0 #(
    .FREE_CLOCK_FREQ(10), .LANE_NUM(4), .LANE_EN(8'hFF),
    .PLL_SEL(8'h02), .BOND_MODE(1), .PD_DLY_US(2), .RST_DLY_US(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  ipmxb_hsst_lane_pwrup_seq_v2_0 #(
    .FREE_CLOCK_FREQ(10), .LANE_NUM(4), .LANE_EN(8'hFF),
    .PLL_SEL(8'h00), .BOND_MODE(4), .PD_DLY_US(2), .RST_DLY_US(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  ipmxb_hsst_lane_pwrup_seq_v2_0 #(
    .FREE_CLOCK_FREQ(10), .LANE_NUM(4), .LANE_EN(8'h0E),
    .PLL_SEL(8'h00), .BOND_MODE(1), .PD_DLY_US(2), .RST_DLY_US(1)
  ) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  typedef struct {
    int          cyc;
    int          dut;
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sbq[$];

  // Observed word: {PD[3:0], RST[3:0], ready[3:0], pll_lost[3:0]}.
  function automatic logic [15:0] obs(int d);
    case (d)
      0: return {bus_a.P_LANE_PD, bus_a.P_LANE_RST,
                 bus_a.o_lane_ready, bus_a.o_pll_lost};
      1: return {bus_b.P_LANE_PD, bus_b.P_LANE_RST,
                 bus_b.o_lane_ready, bus_b.o_pll_lost};
      default: return {bus_c.P_LANE_PD, bus_c.P_LANE_RST,
                       bus_c.o_lane_ready, bus_c.o_pll_lost};
    endcase
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(int d, int c, string tag, logic [15:0] e);
    sb_t s;
    s.cyc = c;
    s.dut = d;
    s.tag = tag;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic goto(int n);
    do @(negedge clk); while (cyc < n);
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        chk(sbq[i].tag, obs(sbq[i].dut), sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  initial begin
    bus_a.i_lane_pd = 4'hF; bus_a.i_pll_done = 2'b00;
    bus_a.i_clr_status = 1'b0;
    bus_b.i_lane_pd = 4'hF; bus_b.i_pll_done = 2'b00;
    bus_b.i_clr_status = 1'b0;
    bus_c.i_lane_pd = 4'hF; bus_c.i_pll_done = 2'b00;
    bus_c.i_clr_status = 1'b0;

    goto(1);
    push(0, 2, "rst_a", 16'hFF00);
    push(1, 2, "rst_b", 16'hFF00);
    push(2, 2, "rst_c", 16'hFF00);

    goto(3);
    rst = 1'b0;
    bus_a.i_pll_done = 2'b11;
    bus_b.i_pll_done = 2'b01;
    bus_c.i_pll_done = 2'b11;

    // Lane 2 alone; PD_WAIT entered at edge 12.
    goto(8);
    bus_a.i_lane_pd = 4'b1011;
    push(0, 51, "a_l2_pd_hold", 16'hFF00);
    push(0, 52, "a_l2_pd_fall", 16'hBF00);
    push(0, 71, "a_l2_rst_hold", 16'hBF00);
    push(0, 72, "a_l2_ready", 16'hBB40);
    // Bond group: non-master request has no effect.
    bus_b.i_lane_pd = 4'b0111;
    push(1, 28, "b_slave_pd_ign", 16'hFF00);
    // Lane 0 disabled: ignores its own release.
    bus_c.i_lane_pd = 4'b0000;
    push(2, 51, "c_pd_hold", 16'hFF00);
    push(2, 52, "c_pd_fall", 16'h1F00);
    push(2, 72, "c_ready", 16'h11E0);
    push(2, 200, "c_l0_off", 16'h11E0);

    goto(40);
    bus_b.i_lane_pd = 4'b1110;
    push(1, 41, "b_still_off", 16'hFF00);
    push(1, 83, "b_pd_hold", 16'hFF00);
    push(1, 84, "b_pd_fall", 16'h0F00);
    push(1, 103, "b_rst_hold", 16'h0F00);
    push(1, 104, "b_ready", 16'h00F0);

    goto(80);
    bus_a.i_lane_pd = 4'b1000;
    push(0, 123, "a_l01_pd_hold", 16'hBB40);
    push(0, 124, "a_l01_pd_fall", 16'h8B40);
    push(0, 144, "a_l01_ready", 16'h8870);

    // PLL1 loss hits lane 1 only.
    goto(150);
    bus_a.i_pll_done = 2'b01;
    push(0, 152, "a_pll1_pre", 16'h8870);
    push(0, 153, "a_pll1_lost", 16'hAA52);

    goto(160);
    bus_a.i_pll_done = 2'b11;
    push(0, 202, "a_reseq_pd_hold", 16'hAA52);
    push(0, 203, "a_reseq_pd_fall", 16'h8A52);
    push(0, 222, "a_reseq_rst_hold", 16'h8A52);
    push(0, 223, "a_reseq_ready", 16'h8872);
    push(0, 229, "a_lost_sticky", 16'h8872);

    goto(230);
    bus_a.i_clr_status = 1'b1;
    push(0, 231, "a_lost_clr", 16'h8870);
    goto(231);
    bus_a.i_clr_status = 1'b0;

    // Bring lane 0 into RST_WAIT, then pd + PLL0 loss together.
    goto(240);
    bus_a.i_lane_pd = 4'b1001;
    push(0, 243, "a_l0_off", 16'h9960);
    goto(245);
    bus_a.i_lane_pd = 4'b1000;
    push(0, 296, "a_l0_rst_wait", 16'h8960);

    goto(296);
    bus_a.i_lane_pd = 4'b1001;
    bus_a.i_pll_done = 2'b10;
    push(0, 298, "a_pd_pll_pre", 16'h8960);
    push(0, 299, "a_pd_wins", 16'hDD24);

    // Lane 2 re-enters PD_WAIT at edge 313; counter is 25 at edge 338.
    goto(310);
    bus_a.i_lane_pd = 4'b1011;
    bus_a.i_pll_done = 2'b11;
    push(0, 337, "a_l2_pdwait", 16'hFF04);

    goto(338);
    rst = 1'b1;
    #1;
    chk("a_async_rst", obs(0), 16'hFF00);
    chk("b_async_rst", obs(1), 16'hFF00);
    chk("c_async_rst", obs(2), 16'hFF00);

    goto(341);
    rst = 1'b0;
    push(0, 384, "a_rst_pd_hold", 16'hFF00);
    push(0, 385, "a_rst_pd_fall", 16'hBF00);
    push(0, 404, "a_rst_rst_hold", 16'hBF00);
    push(0, 405, "a_rst_ready", 16'hBB40);

    goto(410);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ipmxb_hsst_lane_pwrup_seq_v2_0.md
# ipmxb_hsst_lane_pwrup_seq_v2_0

Parametrised per-lane power-up sequencer for the HSST transceiver wrapper. It replaces the fixed four-lane power-up logic and supports 1–8 lanes, per-lane PLL selection and lane bonding groups of 1, 2 or 4. Each lane runs a state machine that drives its power-down and reset controls. New in this version: PLL-loss re-sequencing, a per-lane ready indication and a sticky PLL-loss status. The block sits between the free-running clock domain and the HSST hard macro lane controls.

## Interface
- FREE_CLOCK_FREQ, 100, free clock frequency in MHz (1–200).
- LANE_NUM, 4, number of lanes (1–8).
- LANE_EN, 8'hFF, per-lane enable mask; bit i=0 holds lane i powered down.
- PLL_SEL, 8'h00, per-lane PLL select; bit i=0 selects PLL0, 1 selects PLL1.
- BOND_MODE, 1, lanes per bonding group (1, 2 or 4); LANE_NUM must be a multiple of BOND_MODE.
- PD_DLY_US, 40, power-up delay in µs before PD release.
- RST_DLY_US, 1, delay in µs between PD release and RST release.
- Derived: PD_CYCLES = 2·PD_DLY_US·FREE_CLOCK_FREQ; RST_CYCLES = 2·RST_DLY_US·FREE_CLOCK_FREQ; CNTR_WIDTH = $clog2(max(PD_CYCLES, RST_CYCLES)+1).

Ports:
- clk  in  1  free-running clock.
- rst  in  1  asynchronous, active-high reset.
- i_lane_pd  in  LANE_NUM  per-lane power-down request; asynchronous, 1 = power down.
- i_pll_done  in  2  PLL0/PLL1 lock-done; asynchronous.
- i_clr_status  in  1  synchronous pulse that clears o_pll_lost.
- P_LANE_PD  out  LANE_NUM  lane power-down to HSST; 1 = powered down.
- P_LANE_RST  out  LANE_NUM  lane reset to HSST; 1 = in reset.
- o_lane_ready  out  LANE_NUM  lane sequenced and out of reset.
- o_pll_lost  out  LANE_NUM  sticky flag: PLL lost while lane past WAIT_PLL.

## Operation
- **Synchronisers.** i_lane_pd and i_pll_done each pass through a 2-flop synchroniser.
  - Reset values: pd flops reset to 1; pll flops reset to 0.
- **Group structure.** One FSM and one counter per group; group g = lanes g·BOND_MODE … g·BOND_MODE+BOND_MODE−1.
  - Master lane = lowest index in the group. The FSM uses the master's LANE_EN, PLL_SEL and synced pd.
  - All group lanes output the master's values. A non-master lane's own i_lane_pd and LANE_EN bit are ignored.
  - Disabled master: group outputs fixed PD=1, RST=1, ready=0, pll_lost=0.
- **FSM states:** OFF, WAIT_PLL, PD_WAIT, RST_WAIT, READY.
  - OFF: PD=1, RST=1. Moves to WAIT_PLL when synced pd=0.
  - WAIT_PLL: PD=1, RST=1. Moves to PD_WAIT (counter cleared to 0) when the selected synced pll_done=1.
  - PD_WAIT: PD=1, RST=1, counter increments each cycle. When counter == PD_CYCLES−1, moves to RST_WAIT with counter cleared.
  - RST_WAIT: PD=0, RST=1, counter increments. When counter == RST_CYCLES−1, moves to READY.
  - READY: PD=0, RST=0, ready=1; counter held.
- **Priority, evaluated every cycle, in any state:**
  1. Synced pd=1 → OFF. This overrides PLL loss, so no o_pll_lost set.
  2. Else, in PD_WAIT, RST_WAIT or READY, selected pll_done=0 → WAIT_PLL and set o_pll_lost for the group's lanes.
  3. Else, normal transition.
- **o_pll_lost.**
  - Set and clear on the same cycle: set wins.
  - Not cleared by re-sequencing.
- **Counter.** Unsigned, CNTR_WIDTH bits. It never wraps, because it is cleared on every state entry.

## Timing
- All outputs are registered; outputs are a direct decode of the state register.
- Reset values: P_LANE_PD = all 1, P_LANE_RST = all 1, o_lane_ready = 0, o_pll_lost = 0, all FSMs in OFF, counters 0.
- Input latency: an input change is seen by the FSM 2 clk edges after it is sampled.
- Sequence timing: if PD_WAIT is entered at edge N:
  - P_LANE_PD falls at edge N+PD_CYCLES.
  - P_LANE_RST falls and o_lane_ready rises at edge N+PD_CYCLES+RST_CYCLES.
- Abort timing: a pd request or PLL loss reaches the outputs (PD=1, RST=1, ready=0) one edge after the synced value changes.
- Reset asserted mid-sequence: all outputs go to reset values immediately (asynchronous). Deassertion restarts from OFF.
- Glitch rule: i_pll_done pulses shorter than one clk period may be missed; no filtering is required.

## Test plan
Parameters: FREE_CLOCK_FREQ=10, PD_DLY_US=2, RST_DLY_US=1, so PD_CYCLES=40 and RST_CYCLES=20.
1. Basic sequence: BOND_MODE=1, LANE_NUM=4, both PLLs done, release i_lane_pd[2] → lane 2 PD falls exactly 40 edges after PD_WAIT entry, RST falls and ready rises 20 edges later. Other lanes stay PD=1, RST=1.
2. PLL loss in READY: lane 1 with PLL_SEL[1]=1, drop i_pll_done[1] → lane 1 PD=1, RST=1, ready=0 and o_pll_lost[1]=1. Lane 0 (PLL0) is unaffected. Restore PLL → full 40+20 sequence reruns and o_pll_lost[1] stays 1 until i_clr_status.
3. pd wins over PLL loss: assert i_lane_pd[0] and drop PLL0 on the same edge while lane 0 is in RST_WAIT → lane 0 enters OFF and o_pll_lost[0] stays 0.
4. Bonding: BOND_MODE=4, LANE_NUM=4, toggle only i_lane_pd[3] → no effect. Release i_lane_pd[0] → all four lanes' PD and RST fall on the same edges.
5. Disabled lane: LANE_EN=8'h0E → lane 0 outputs PD=1, RST=1, ready=0 for all stimulus.
6. Reset mid-operation: assert rst at counter=25 in PD_WAIT → outputs go to reset values immediately. After release, the sequence restarts and PD falls 40 edges after the new PD_WAIT entry.
